// File: rtl/matmul_stream_ctrl.sv
// rtl/matmul_stream_ctrl.sv - streams A/B rows into engine memories, kicks the engine, streams result rows out.
// Optional engine-latency counter: MATMUL_STREAM_CTRL_CYCLE_CNT_EN.
module matmul_stream_ctrl #(
    parameter int MUL_SIZE  = 8,
    parameter int ADDR_BITS = $clog2(MUL_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [MUL_SIZE*8-1:0]   s_data,
    output logic                    a_we,
    output logic [ADDR_BITS-1:0]    a_waddr,
    output logic [MUL_SIZE*8-1:0]   a_wdata,
    output logic                    b_we,
    output logic [ADDR_BITS-1:0]    b_waddr,
    output logic [MUL_SIZE*8-1:0]   b_wdata,
    output logic                    start_mul,
    input  logic                    mul_done,
    output logic [ADDR_BITS-1:0]    out_raddr,
    input  logic [MUL_SIZE*8-1:0]   out_rdata,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [MUL_SIZE*8-1:0]   m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic [31:0]             calc_cycles
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(MUL_SIZE - 1);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        RD_ADDR,
        RD_DATA,
        SEND
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] cnt;

    // Gated by rst so s_ready is also low while reset is held.
    assign s_ready = rst && ((state == LOAD_A) || (state == LOAD_B));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD_A;
            cnt       <= '0;
            a_we      <= 1'b0;
            a_waddr   <= '0;
            a_wdata   <= '0;
            b_we      <= 1'b0;
            b_waddr   <= '0;
            b_wdata   <= '0;
            start_mul <= 1'b0;
            out_raddr <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            a_we      <= 1'b0;
            b_we      <= 1'b0;
            start_mul <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (s_valid) begin
                        a_we    <= 1'b1;
                        a_waddr <= cnt;
                        a_wdata <= s_data;
                        cnt     <= cnt + 1'b1;
                        busy    <= 1'b1;
                        if (cnt == LAST) state <= LOAD_B;
                    end else begin
                        busy <= (cnt != '0);
                    end
                end
                LOAD_B: begin
                    if (s_valid) begin
                        b_we    <= 1'b1;
                        b_waddr <= cnt;
                        b_wdata <= s_data;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST) state <= START;
                    end
                end
                // The final b_we is on the bus during this state, so start lands one cycle later.
                START: begin
                    start_mul <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        cnt       <= '0;
                        out_raddr <= '0;
                        state     <= RD_ADDR;
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    m_data  <= out_rdata;
                    m_valid <= 1'b1;
                    m_last  <= (cnt == LAST);
                    state   <= SEND;
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= LOAD_A;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            out_raddr <= cnt + 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

`ifdef MATMUL_STREAM_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;

    // The mul_done cycle itself is not counted, so the value equals the start-to-done distance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
        end else if (state == START) begin
            cyc_cnt <= '0;
        end else if ((state == WAIT) && !mul_done && (cyc_cnt != 32'hFFFF_FFFF)) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    assign calc_cycles = cyc_cnt;
`else
    assign calc_cycles = '0;
`endif

endmodule

// File: doc/matmul_stream_ctrl.md
Name: matmul_stream_ctrl

Overview:
- Host-side counterpart of the vector matmul engine's memory interface.
- Accepts a valid/ready stream of matrix rows and writes them into the A and B input memories.
- Pulses start_mul, waits for mul_done, then reads the result memory and emits the result rows as a valid/ready stream.
- Sits between the host/DMA adapter and the A/B/out memories plus the matmul engine.

Parameters:
MUL_SIZE  8  matrix dimension; each row/column is MUL_SIZE bytes
ADDR_BITS  $clog2(MUL_SIZE)  memory address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
s_valid  in  1  input row valid
s_ready  out  1  input row accepted when s_valid && s_ready
s_data  in  MUL_SIZE*8  input row; first MUL_SIZE beats are A rows 0..N-1, next MUL_SIZE beats are B columns 0..N-1
a_we  out  1  A memory write enable
a_waddr  out  ADDR_BITS  A write address
a_wdata  out  MUL_SIZE*8  A write data
b_we  out  1  B memory write enable
b_waddr  out  ADDR_BITS  B write address
b_wdata  out  MUL_SIZE*8  B write data
start_mul  out  1  one-cycle start pulse to engine
mul_done  in  1  one-cycle done pulse from engine
out_raddr  out  ADDR_BITS  result memory read address; synchronous read, data valid next cycle
out_rdata  in  MUL_SIZE*8  result memory read data
m_valid  out  1  result row valid
m_ready  in  1  downstream accepts
m_data  out  MUL_SIZE*8  result row
m_last  out  1  marks row MUL_SIZE-1
busy  out  1  high in every state except LOAD_A with cnt==0
calc_cycles  out  32  engine latency (see Optional Feature)

Behaviour:
- All outputs registered except s_ready, which is decoded from state: high in LOAD_A and LOAD_B only.
- Reset (rst low, async): state=LOAD_A, cnt=0; every output 0, including s_ready and calc_cycles.
- States: LOAD_A, LOAD_B, START, WAIT, RD_ADDR, RD_DATA, SEND.
- LOAD_A: on each handshake, next cycle a_we=1, a_waddr=cnt, a_wdata=s_data; cnt increments. On the handshake with cnt==last: cnt wraps to 0, go to LOAD_B.
- LOAD_B: same, using the b_* ports. On the last handshake: go to START.
- START: start_mul=1 for exactly one cycle. It is asserted the cycle after the final b_we cycle, so all writes are committed first. Then go to WAIT.
- WAIT: s_ready=0. On mul_done go to RD_ADDR with cnt=0. mul_done in any other state is ignored.
- RD_ADDR: out_raddr=cnt for one cycle, then RD_DATA.
- RD_DATA: capture out_rdata into m_data; m_valid=1; m_last=(cnt==last); go to SEND.
- SEND: m_valid and m_data held stable until m_ready.
  - Handshake with cnt!=last: m_valid=0, cnt++, go to RD_ADDR.
  - Handshake with cnt==last: m_valid=0, m_last=0, cnt=0, go to LOAD_A.
- Throughput: one result row per 3 cycles max; input at 1 row/cycle.
- m_ready held low: stall indefinitely in SEND with no data change.
- s_valid gaps: counters hold; no write issued.
- Reset mid-operation: immediate return to reset state. Memory contents are not cleared; the next job overwrites all rows.
- ADDR_BITS counter wraps naturally at 2^ADDR_BITS. MUL_SIZE must be a power of two.

Optional Feature:
- Macro MATMUL_STREAM_CTRL_CYCLE_CNT_EN.
- Defined: 32-bit counter cleared in START, incremented every WAIT cycle, frozen on mul_done. calc_cycles shows the frozen value until the next START. The counter saturates at 0xFFFFFFFF.
- Undefined: no counter logic; calc_cycles tied to 0.

Test Plan:
- Reset idle: rst low, then high, no stimulus -> s_ready=1, busy=0, m_valid=0, start_mul=0, all write enables 0.
- Full job, MUL_SIZE=8: stream A=identity, B columns col j = all bytes j+1, respond mul_done 5 cycles after start_mul, result memory row r = byte r -> 16 writes (a_waddr 0..7 then b_waddr 0..7); start_mul exactly once, one cycle after the last b_we; 8 m_data rows equal to result rows 0..7; m_last only on row 7.
- Backpressure: m_ready low 10 cycles on row 3 -> m_data/m_valid stable; out_raddr not advanced; rows resume in order.
- Input gaps: s_valid toggled every other cycle -> exactly 16 writes, addresses contiguous.
- Stray done and mid-op reset: mul_done pulsed during LOAD_B -> ignored, no read. rst asserted in SEND -> m_valid=0 immediately; next job runs correctly.
- Macro on: mul_done 37 cycles after start_mul -> calc_cycles=37. Macro off: calc_cycles=0.
